// File: rtl/dbus_enb_ctrl_if.sv
// ---------------------------------------------------------------------------
// dbus_enb_ctrl_if
//   Bundles the grant/busy/enable handshake that passes between a bus
//   requester side and the dbus_enb controller.
//
//   Signals:
//     dgrant      data grant. Its rising edge starts a transaction.
//     dbusy_n     bus-free indication. Each high sample counts once.
//     dbus_enb    registered data-bus enable.
//     timeout_err one-cycle pulse when the search window expires.
//     abort       one-cycle pulse when dgrant drops while waiting.
//     busy_cnt    dbusy_n samples counted in the current window.
//     active      high while a transaction is waiting or enabled.
//
//   Modports:
//     master  drives dgrant/dbusy_n and observes the controller outputs.
//     slave   the controller itself.
// ---------------------------------------------------------------------------
interface dbus_enb_ctrl_if;
  logic       dgrant;
  logic       dbusy_n;
  logic       dbus_enb;
  logic       timeout_err;
  logic       abort;
  logic [3:0] busy_cnt;
  logic       active;

  modport master (
    output dgrant,
    output dbusy_n,
    input  dbus_enb,
    input  timeout_err,
    input  abort,
    input  busy_cnt,
    input  active
  );

  modport slave (
    input  dgrant,
    input  dbusy_n,
    output dbus_enb,
    output timeout_err,
    output abort,
    output busy_cnt,
    output active
  );
endinterface

// File: rtl/dbus_enb_ctrl.sv
// ---------------------------------------------------------------------------
// dbus_enb_ctrl
//   Data-bus enable controller. A rising dgrant opens a search window of
//   MAX_CYCLES cycles. Once BUSY_COUNT dbusy_n samples have been counted in
//   that window, dbus_enb is raised the following cycle and held for
//   ENB_CYCLES cycles. If the window runs out first, timeout_err pulses;
//   if dgrant drops while waiting, abort pulses.
//
//   Parameters:
//     MAX_CYCLES  search window length in cycles (2..4096)
//     BUSY_COUNT  dbusy_n samples required before enable (1..15)
//     ENB_CYCLES  cycles dbus_enb stays high (1..255)
//
//   Ports:
//     clk     rising-edge clock
//     rst     synchronous active-high reset
//     io_bus  handshake bundle (slave modport): dgrant, dbusy_n in;
//             dbus_enb, timeout_err, abort, busy_cnt, active out
// ---------------------------------------------------------------------------
module dbus_enb_ctrl #(
  parameter int MAX_CYCLES = 256,
  parameter int BUSY_COUNT = 2,
  parameter int ENB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  dbus_enb_ctrl_if.slave  io_bus
);

  localparam int WIN_W = $clog2(MAX_CYCLES + 1);

  // Terminal values are compared against the count *before* the increment,
  // so the decision lands on the same edge that samples the last input.
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(MAX_CYCLES - 1);
  localparam logic [3:0]       BUSY_LAST = 4'(BUSY_COUNT - 1);
  localparam logic [7:0]       ENB_LAST  = 8'(ENB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ENB  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_dgrant_q;
  logic [WIN_W-1:0] r_win_cnt;
  logic [7:0]       r_enb_cnt;
  logic [3:0]       r_busy_cnt;
  logic             r_dbus_enb;
  logic             r_timeout_err;
  logic             r_abort;
  logic             r_active;

  logic             w_rise;
  logic [3:0]       w_busy_inc;

  // r_dgrant_q resets to 0, so a dgrant already high right after reset is
  // seen as a rise.
  assign w_rise     = io_bus.dgrant & ~r_dgrant_q;
  assign w_busy_inc = (r_busy_cnt == 4'hF) ? r_busy_cnt : r_busy_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dgrant_q    <= 1'b0;
      r_win_cnt     <= '0;
      r_enb_cnt     <= '0;
      r_busy_cnt    <= '0;
      r_dbus_enb    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_abort       <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_dgrant_q    <= io_bus.dgrant;
      r_timeout_err <= 1'b0;
      r_abort       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // dbusy_n on the rise edge itself is deliberately not counted.
          if (w_rise) begin
            r_state    <= S_WAIT;
            r_busy_cnt <= '0;
            r_win_cnt  <= '0;
            r_active   <= 1'b1;
          end
        end

        S_WAIT: begin
          r_win_cnt <= r_win_cnt + 1'b1;
          if (io_bus.dbusy_n) begin
            r_busy_cnt <= w_busy_inc;
          end

          // Priority: abort, then success, then timeout. Success on the
          // final window cycle therefore wins over the timeout.
          if (!io_bus.dgrant) begin
            r_abort  <= 1'b1;
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end else if (io_bus.dbusy_n && (r_busy_cnt == BUSY_LAST)) begin
            r_state    <= S_ENB;
            r_dbus_enb <= 1'b1;
            r_enb_cnt  <= '0;
          end else if (r_win_cnt == WIN_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
            r_active      <= 1'b0;
          end
        end

        S_ENB: begin
          // dgrant/dbusy_n are ignored here; r_dgrant_q keeps tracking, so
          // a rise that happens during ENB is consumed and never replayed.
          if (r_enb_cnt == ENB_LAST) begin
            r_dbus_enb <= 1'b0;
            r_state    <= S_IDLE;
            r_active   <= 1'b0;
          end else begin
            r_enb_cnt <= r_enb_cnt + 8'd1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_dbus_enb <= 1'b0;
          r_active   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.dbus_enb    = r_dbus_enb;
  assign io_bus.timeout_err = r_timeout_err;
  assign io_bus.abort       = r_abort;
  assign io_bus.busy_cnt    = r_busy_cnt;
  assign io_bus.active      = r_active;

endmodule
